arf_list_scheduler: RTL

//  Controller that runs the 28-node ARF dataflow graph on one shared pipelined multiplier and one shared adder.
//  - Node mapping: n1-n8, n15-n18 and n21-n24 are multiplies; all other nodes are adds.
//  - Issue policy: each cycle the controller issues the lowest-index ready node per unit.
//  - Node results are held in an internal register file; y0/y1 return n27/n28 over a valid/ready handshake.

---
 rtl/arf_list_scheduler.sv | 278 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/arf_list_scheduler.sv
// ARF dataflow graph run by list scheduling on one pipelined multiplier and one pipelined adder.
// Build option: define ARF_STATE_FB_EN to feed the previous run's y0/y1 back as the state inputs.
module arf_list_scheduler #(
    parameter int WIDTH   = 16,
    parameter int MUL_LAT = 2,
    parameter int ADD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [8*WIDTH-1:0]    x_flat,
    input  logic [16*WIDTH-1:0]   coef_flat,
    input  logic [2*WIDTH-1:0]    st_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      y0,
    output logic [WIDTH-1:0]      y1,
    output logic                  busy
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Bit i set when node i+1 runs on the multiplier.
    localparam logic [27:0] MUL_MASK = 28'h0F3C0FF;
    localparam logic [4:0]  EXT      = 5'd31;

    // Operand node indices {a, b} for node index n; EXT marks an input register operand.
    function automatic logic [9:0] srcs(input logic [4:0] n);
        case (n)
            5'd8:    srcs = {5'd0,  5'd1};
            5'd9:    srcs = {5'd2,  5'd3};
            5'd10:   srcs = {5'd4,  5'd5};
            5'd11:   srcs = {5'd6,  5'd7};
            5'd12:   srcs = {5'd9,  EXT};
            5'd13:   srcs = {5'd10, EXT};
            5'd14:   srcs = {5'd12, EXT};
            5'd15:   srcs = {5'd13, EXT};
            5'd16:   srcs = {5'd12, EXT};
            5'd17:   srcs = {5'd13, EXT};
            5'd18:   srcs = {5'd14, 5'd15};
            5'd19:   srcs = {5'd16, 5'd17};
            5'd20:   srcs = {5'd18, EXT};
            5'd21:   srcs = {5'd19, EXT};
            5'd22:   srcs = {5'd18, EXT};
            5'd23:   srcs = {5'd19, EXT};
            5'd24:   srcs = {5'd20, 5'd21};
            5'd25:   srcs = {5'd22, 5'd23};
            5'd26:   srcs = {5'd8,  5'd24};
            5'd27:   srcs = {5'd11, 5'd25};
            default: srcs = {EXT,   EXT};
        endcase
    endfunction

    function automatic logic [27:0] deps(input logic [4:0] n);
        logic [9:0] s;
        s    = srcs(n);
        deps = '0;
        if (s[9:5] != EXT) deps[s[9:5]] = 1'b1;
        if (s[4:0] != EXT) deps[s[4:0]] = 1'b1;
    endfunction

    function automatic logic [3:0] coef_sel(input logic [4:0] n);
        if (n < 5'd8)       coef_sel = n[3:0];
        else if (n < 5'd20) coef_sel = 4'(n - 5'd6);
        else                coef_sel = 4'(n - 5'd8);
    endfunction

    state_t           state_d, state_q;
    logic [27:0]      issued_d, issued_q, done_d, done_q;
    logic [WIDTH-1:0] rf_d [28];
    logic [WIDTH-1:0] rf_q [28];
    logic [WIDTH-1:0] x_d [8];
    logic [WIDTH-1:0] x_q [8];
    logic [WIDTH-1:0] coef_d [16];
    logic [WIDTH-1:0] coef_q [16];
    logic [WIDTH-1:0] st_d [2];
    logic [WIDTH-1:0] st_q [2];
    logic [WIDTH-1:0] y0_d, y0_q, y1_d, y1_q;

    logic                    mul_go, add_go;
    logic [4:0]              mul_sel, add_sel;
    logic [9:0]              ms, as;
    logic signed [WIDTH-1:0] mul_a, mul_b, mul_p, add_a, add_b, add_s;
    logic                    mul_wb_vld, add_wb_vld;
    logic [4:0]              mul_wb_id, add_wb_id;
    logic [WIDTH-1:0]        mul_wb_res, add_wb_res;

    // Lowest-index ready node per unit; iterating downward lets the lowest one win.
    always_comb begin
        mul_go  = 1'b0;
        mul_sel = '0;
        add_go  = 1'b0;
        add_sel = '0;
        for (int k = 27; k >= 0; k--) begin
            if (state_q == RUN && !issued_q[k] &&
                ((done_q & deps(5'(k))) == deps(5'(k)))) begin
                if (MUL_MASK[k]) begin
                    mul_go  = 1'b1;
                    mul_sel = 5'(k);
                end else begin
                    add_go  = 1'b1;
                    add_sel = 5'(k);
                end
            end
        end
    end

    always_comb begin
        ms    = srcs(mul_sel);
        as    = srcs(add_sel);
        mul_a = (ms[9:5] == EXT) ? x_q[mul_sel[2:0]] : rf_q[ms[9:5]];
        mul_b = (ms[4:0] == EXT) ? coef_q[coef_sel(mul_sel)] : rf_q[ms[4:0]];
        add_a = rf_q[as[9:5]];
        add_b = (as[4:0] == EXT) ? st_q[add_sel == 5'd13] : rf_q[as[4:0]];
        mul_p = mul_a * mul_b;
        add_s = add_a + add_b;
    end

    // Latency pipelines: a unit with latency L writes back L-1 edges after the issue edge.
    if (MUL_LAT == 1) begin : g_mul_direct
        always_comb begin
            mul_wb_vld = mul_go;
            mul_wb_id  = mul_sel;
            mul_wb_res = mul_p;
        end
    end else begin : g_mul_pipe
        logic [MUL_LAT-2:0] vld_d, vld_q;
        logic [4:0]         id_d [MUL_LAT-1];
        logic [4:0]         id_q [MUL_LAT-1];
        logic [WIDTH-1:0]   res_d [MUL_LAT-1];
        logic [WIDTH-1:0]   res_q [MUL_LAT-1];
        always_comb begin
            vld_d[0] = mul_go;
            id_d[0]  = mul_sel;
            res_d[0] = mul_p;
            for (int i = 1; i < MUL_LAT-1; i++) begin
                vld_d[i] = vld_q[i-1];
                id_d[i]  = id_q[i-1];
                res_d[i] = res_q[i-1];
            end
            mul_wb_vld = vld_q[MUL_LAT-2];
            mul_wb_id  = id_q[MUL_LAT-2];
            mul_wb_res = res_q[MUL_LAT-2];
        end
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= '0;
                for (int i = 0; i < MUL_LAT-1; i++) begin
                    id_q[i]  <= '0;
                    res_q[i] <= '0;
                end
            end else begin
                vld_q <= vld_d;
                id_q  <= id_d;
                res_q <= res_d;
            end
        end
    end

    if (ADD_LAT == 1) begin : g_add_direct
        always_comb begin
            add_wb_vld = add_go;
            add_wb_id  = add_sel;
            add_wb_res = add_s;
        end
    end else begin : g_add_pipe
        logic [ADD_LAT-2:0] vld_d, vld_q;
        logic [4:0]         id_d [ADD_LAT-1];
        logic [4:0]         id_q [ADD_LAT-1];
        logic [WIDTH-1:0]   res_d [ADD_LAT-1];
        logic [WIDTH-1:0]   res_q [ADD_LAT-1];
        always_comb begin
            vld_d[0] = add_go;
            id_d[0]  = add_sel;
            res_d[0] = add_s;
            for (int i = 1; i < ADD_LAT-1; i++) begin
                vld_d[i] = vld_q[i-1];
                id_d[i]  = id_q[i-1];
                res_d[i] = res_q[i-1];
            end
            add_wb_vld = vld_q[ADD_LAT-2];
            add_wb_id  = id_q[ADD_LAT-2];
            add_wb_res = res_q[ADD_LAT-2];
        end
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_q <= '0;
                for (int i = 0; i < ADD_LAT-1; i++) begin
                    id_q[i]  <= '0;
                    res_q[i] <= '0;
                end
            end else begin
                vld_q <= vld_d;
                id_q  <= id_d;
                res_q <= res_d;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        issued_d = issued_q;
        done_d   = done_q;
        rf_d     = rf_q;
        x_d      = x_q;
        coef_d   = coef_q;
        st_d     = st_q;
        y0_d     = y0_q;
        y1_d     = y1_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d  = RUN;
                    issued_d = '0;
                    done_d   = '0;
                    for (int i = 0; i < 8; i++)  x_d[i]    = x_flat[i*WIDTH +: WIDTH];
                    for (int i = 0; i < 16; i++) coef_d[i] = coef_flat[i*WIDTH +: WIDTH];
`ifdef ARF_STATE_FB_EN
                    st_d[0] = y0_q;
                    st_d[1] = y1_q;
`else
                    st_d[0] = st_in[WIDTH-1:0];
                    st_d[1] = st_in[2*WIDTH-1:WIDTH];
`endif
                end
            end
            RUN: begin
                if (mul_go) issued_d[mul_sel] = 1'b1;
                if (add_go) issued_d[add_sel] = 1'b1;
                if (mul_wb_vld) begin
                    done_d[mul_wb_id] = 1'b1;
                    rf_d[mul_wb_id]   = mul_wb_res;
                end
                if (add_wb_vld) begin
                    done_d[add_wb_id] = 1'b1;
                    rf_d[add_wb_id]   = add_wb_res;
                    if (add_wb_id == 5'd26) y0_d = add_wb_res;
                    if (add_wb_id == 5'd27) y1_d = add_wb_res;
                end
                if (done_d[27:26] == 2'b11) state_d = DONE;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            issued_q <= '0;
            done_q   <= '0;
            y0_q     <= '0;
            y1_q     <= '0;
            for (int i = 0; i < 28; i++) rf_q[i]   <= '0;
            for (int i = 0; i < 8; i++)  x_q[i]    <= '0;
            for (int i = 0; i < 16; i++) coef_q[i] <= '0;
            for (int i = 0; i < 2; i++)  st_q[i]   <= '0;
        end else begin
            state_q  <= state_d;
            issued_q <= issued_d;
            done_q   <= done_d;
            y0_q     <= y0_d;
            y1_q     <= y1_d;
            rf_q     <= rf_d;
            x_q      <= x_d;
            coef_q   <= coef_d;
            st_q     <= st_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == RUN);
    assign out_valid = (state_q == DONE);
    assign y0        = y0_q;
    assign y1        = y1_q;
endmodule
